// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared encodings for the memory-stage load/store unit.
//   - access size codes presented by EX/MEM
//   - trunk (extension) mode codes, shared with the write-back extension stage
//   - FSM state encoding for mem_access_unit
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;   // 2'd3 is also treated as a word

    localparam logic [2:0] TM_PASS   = 3'd0;
    localparam logic [2:0] TM_BYTE_S = 3'd1;
    localparam logic [2:0] TM_HALF_S = 3'd2;
    localparam logic [2:0] TM_BYTE_U = 3'd3;
    localparam logic [2:0] TM_HALF_U = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mau_state_e;

    // Natural alignment: bytes never fault, halves need addr[0]=0,
    // words (and the size-3 alias) need addr[1:0]=0.
    function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: addr_aligned = 1'b1;
            SZ_HALF: addr_aligned = ~lo[0];
            default: addr_aligned = (lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory port bundle (req/ack handshake).
//   dmem_req/we/addr/be/wdata : request side, driven by the load/store unit
//   dmem_ack/rdata            : completion side, driven by the memory
// Modports: master = load/store unit, slave = memory.
interface mem_access_unit_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_access_unit_byte_lane_align.sv
// byte_lane_align: purely combinational lane steering for the load/store unit.
//   i_size, i_addr_lo, i_unsigned : access shape (size code, addr[1:0], LBU/LHU)
//   i_wdata                       : store value in the low bits
//   i_rdata                       : word returned by memory
//   o_be, o_wdata                 : byte enables and lane-replicated store data
//   o_load_data, o_trunk_mode     : right-aligned load value and extension mode
module byte_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic [2:0]  o_trunk_mode
);

    logic [31:0] w_shifted;

    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        w_shifted    = i_rdata;
        o_load_data  = i_rdata;
        o_trunk_mode = TM_PASS;
        case (i_size)
            SZ_BYTE: begin
                o_be         = 4'b0001 << i_addr_lo;
                o_wdata      = {4{i_wdata[7:0]}};
                w_shifted    = i_rdata >> {i_addr_lo, 3'b000};
                // Bits above the access width are cleared; sign/zero
                // extension happens downstream from o_trunk_mode.
                o_load_data  = {24'd0, w_shifted[7:0]};
                o_trunk_mode = i_unsigned ? TM_BYTE_U : TM_BYTE_S;
            end
            SZ_HALF: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                w_shifted    = i_rdata >> {i_addr_lo[1], 4'b0000};
                o_load_data  = {16'd0, w_shifted[15:0]};
                o_trunk_mode = i_unsigned ? TM_HALF_U : TM_HALF_S;
            end
            default: ;   // word: full enables, data passes straight through
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit.
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_ex_*                   : EX/MEM access (valid, read, write, size, unsigned, addr, wdata)
//   o_stall                  : hold EX/MEM and upstream while an access is outstanding
//   dmem                     : data-memory req/ack port (master side)
//   o_wb_valid               : one-cycle pulse when a load result is registered
//   o_wb_load_data           : right-aligned load data (held until next load)
//   o_wb_trunk_mode          : extension mode for the write-back stage
//   o_misaligned             : one-cycle pulse on a misaligned access
module mem_access_unit
    import mem_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ex_valid,
    input  logic               i_ex_mem_read,
    input  logic               i_ex_mem_write,
    input  logic [1:0]         i_ex_size,
    input  logic               i_ex_unsigned,
    input  logic [31:0]        i_ex_addr,
    input  logic [31:0]        i_ex_wdata,
    output logic               o_stall,
    mem_access_unit_if.master  dmem,
    output logic               o_wb_valid,
    output logic [31:0]        o_wb_load_data,
    output logic [2:0]         o_wb_trunk_mode,
    output logic               o_misaligned
);

    mau_state_e  r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic [1:0]  r_addr_lo;
    logic        r_unsigned;
    logic        r_wb_valid;
    logic [31:0] r_wb_load_data;
    logic [2:0]  r_wb_trunk_mode;
    logic        r_misaligned;

    logic        w_idle;
    logic        w_busy;
    logic        w_access;
    logic        w_aligned;
    logic        w_accept;
    logic        w_misalign;
    logic [1:0]  w_sel_size;
    logic [1:0]  w_sel_addr_lo;
    logic        w_sel_unsigned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic [2:0]  w_trunk_mode;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_busy     = (r_state == ST_BUSY);
    assign w_access   = i_ex_valid & (i_ex_mem_read | i_ex_mem_write);
    assign w_aligned  = addr_aligned(i_ex_size, i_ex_addr[1:0]);
    assign w_accept   = w_idle & w_access & w_aligned;
    assign w_misalign = w_idle & w_access & ~w_aligned;

    // Upstream may advance in the ack cycle, so stall drops as ack arrives.
    assign o_stall = w_accept | (w_busy & ~dmem.dmem_ack);

    // One steering instance serves both directions: store lanes are only
    // needed in IDLE (from EX/MEM), load alignment only in BUSY (latched).
    assign w_sel_size     = w_busy ? r_size     : i_ex_size;
    assign w_sel_addr_lo  = w_busy ? r_addr_lo  : i_ex_addr[1:0];
    assign w_sel_unsigned = w_busy ? r_unsigned : i_ex_unsigned;

    byte_lane_align u_align (
        .i_size       (w_sel_size),
        .i_addr_lo    (w_sel_addr_lo),
        .i_unsigned   (w_sel_unsigned),
        .i_wdata      (i_ex_wdata),
        .i_rdata      (dmem.dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_trunk_mode (w_trunk_mode)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_req           <= 1'b0;
            r_we            <= 1'b0;
            r_addr          <= 32'd0;
            r_be            <= 4'd0;
            r_wdata         <= 32'd0;
            r_size          <= SZ_BYTE;
            r_addr_lo       <= 2'd0;
            r_unsigned      <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_load_data  <= 32'd0;
            r_wb_trunk_mode <= TM_PASS;
            r_misaligned    <= 1'b0;
        end else begin
            r_misaligned <= w_misalign;
            r_wb_valid   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Any ack seen here belongs to nothing and is ignored.
                    if (w_accept) begin
                        r_state    <= ST_BUSY;
                        r_req      <= 1'b1;
                        r_we       <= ~i_ex_mem_read;   // read wins if both set
                        r_addr     <= {i_ex_addr[31:2], 2'b00};
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                        r_size     <= i_ex_size;
                        r_addr_lo  <= i_ex_addr[1:0];
                        r_unsigned <= i_ex_unsigned;
                    end
                end
                ST_BUSY: begin
                    if (dmem.dmem_ack) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_wb_valid      <= 1'b1;
                            r_wb_load_data  <= w_load_data;
                            r_wb_trunk_mode <= w_trunk_mode;
                        end
                    end
                end
            endcase
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;

    assign o_wb_valid      = r_wb_valid;
    assign o_wb_load_data  = r_wb_load_data;
    assign o_wb_trunk_mode = r_wb_trunk_mode;
    assign o_misaligned    = r_misaligned;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + randomized checks of mem_access_unit against
// a lane-by-lane reference model of the access rules.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_load_data;
    logic [2:0]  wb_trunk_mode;
    logic        misaligned;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_data;
    logic [2:0]  last_mode;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_ex_valid      (ex_valid),
        .i_ex_mem_read   (ex_mem_read),
        .i_ex_mem_write  (ex_mem_write),
        .i_ex_size       (ex_size),
        .i_ex_unsigned   (ex_unsigned),
        .i_ex_addr       (ex_addr),
        .i_ex_wdata      (ex_wdata),
        .o_stall         (stall),
        .dmem            (bus.master),
        .o_wb_valid      (wb_valid),
        .o_wb_load_data  (wb_load_data),
        .o_wb_trunk_mode (wb_trunk_mode),
        .o_misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one EX/MEM slot in the current cycle (entered just after a
    // rising edge, unit idle) and plays memory with ack after dly wait cycles.
    // Returns just after the edge following the ack (or the presentation
    // cycle if nothing was accepted), so a caller can present back-to-back.
    task automatic access(input bit v, input bit rd, input bit wr, input logic [1:0] sz,
                          input bit uns, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rword, input int dly, input bit idle_ack);
        int  nb, base;
        bit  acc, al, ld;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld;
        logic [2:0]  emode;
        acc  = v && (rd || wr);
        ld   = rd;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = int'(a[1:0]);
        al   = (base % nb) == 0;
        ebe = '0; ewd = '0; eld = '0;
        for (int i = 0; i < 4; i++) begin
            ebe[i] = (i >= base) && (i < base + nb);
            ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        for (int j = 0; j < nb; j++) eld[8*j +: 8] = rword[8*(base + j) +: 8];
        emode = (nb == 4) ? 3'd0 : (nb == 1) ? (uns ? 3'd3 : 3'd1) : (uns ? 3'd4 : 3'd2);

        ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_size = sz;
        ex_unsigned = uns; ex_addr = a; ex_wdata = wd;
        bus.dmem_ack = idle_ack; bus.dmem_rdata = $urandom;
        #1;
        chk("stall_present", stall, acc && al);
        @(posedge clk); #1;
        // Scramble EX/MEM to prove the bus runs from the latched copy.
        ex_valid = 1'b0; ex_addr = $urandom; ex_wdata = $urandom;
        ex_size = 2'($urandom); ex_unsigned = 1'($urandom);
        bus.dmem_ack = 1'b0;
        chk("misaligned", misaligned, acc && !al);
        chk("wb_pulse_end", wb_valid, 1'b0);
        if (!(acc && al)) begin
            chk("no_req", bus.dmem_req, 1'b0);
            chk("no_stall", stall, 1'b0);
            return;
        end
        for (int n = 0; n <= dly; n++) begin
            chk("req", bus.dmem_req, 1'b1);
            chk("we", bus.dmem_we, !ld);
            chk("addr", bus.dmem_addr, {a[31:2], 2'b00});
            chk("be", bus.dmem_be, ebe);
            if (!ld) chk("wdata", bus.dmem_wdata, ewd);
            if (n == dly) begin
                bus.dmem_ack = 1'b1; bus.dmem_rdata = rword;
            end else begin
                bus.dmem_rdata = $urandom;
            end
            #1;
            chk("stall_busy", stall, n != dly);
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
        end
        chk("wb_valid", wb_valid, ld);
        if (ld) begin
            last_data = eld; last_mode = emode;
        end
        chk("wb_data", wb_load_data, last_data);
        chk("wb_mode", wb_trunk_mode, last_mode);
        chk("req_drop", bus.dmem_req, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_size = 2'd0; ex_unsigned = 1'b0; ex_addr = '0; ex_wdata = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        last_data = '0; last_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", bus.dmem_req, 1'b0);
        chk("rst_we", bus.dmem_we, 1'b0);
        chk("rst_addr", bus.dmem_addr, 32'd0);
        chk("rst_be", bus.dmem_be, 4'd0);
        chk("rst_wdata", bus.dmem_wdata, 32'd0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_data", wb_load_data, 32'd0);
        chk("rst_wb_mode", wb_trunk_mode, 3'd0);
        chk("rst_misaligned", misaligned, 1'b0);
        chk("rst_stall", stall, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LB 0x103: be 1000, data 0x80, mode 1, ack on first req cycle.
        access(1, 1, 0, 2'd0, 0, 32'h0000_0103, $urandom, 32'h80FF_1234, 0, 0);
        chk("lb_data_const", wb_load_data, 32'h0000_0080);
        // SH 0x202: be 1100, wdata ABCDABCD, addr 0x200.
        access(1, 0, 1, 2'd1, 0, 32'h0000_0202, 32'h0000_ABCD, $urandom, 0, 0);
        // LW 0x40 with a slow memory.
        access(1, 1, 0, 2'd2, 0, 32'h0000_0040, $urandom, 32'hDEAD_BEEF, 2, 0);
        chk("lw_data_const", wb_load_data, 32'hDEAD_BEEF);
        // Misaligned LHU / LW.
        access(1, 1, 0, 2'd1, 1, 32'h0000_0041, $urandom, $urandom, 0, 0);
        access(1, 1, 0, 2'd2, 0, 32'h0000_0042, $urandom, $urandom, 0, 0);
        // Read wins when both strobes set; size 3 acts as a word.
        access(1, 1, 1, 2'd3, 1, 32'h0000_0304, 32'h1111_2222, 32'h0102_0304, 1, 0);

        // Reset while BUSY, then a stray ack after release.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_size = 2'd2; ex_addr = 32'h0000_0080;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("mid_req", bus.dmem_req, 1'b1);
        rst_n = 1'b0; #1;
        chk("mid_rst_req", bus.dmem_req, 1'b0);
        chk("mid_rst_stall", stall, 1'b0);
        last_data = '0; last_mode = '0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        chk("late_ack_wb", wb_valid, 1'b0);
        chk("late_ack_req", bus.dmem_req, 1'b0);
        // LBU at 0x1 after reset.
        access(1, 1, 0, 2'd0, 1, 32'h0000_0001, $urandom, 32'h0000_9A00, 0, 0);
        chk("lbu_data_const", wb_load_data, 32'h0000_009A);
        // Back-to-back SB then LH.
        access(1, 0, 1, 2'd0, 0, 32'h0000_0007, 32'h0000_005A, $urandom, 1, 0);
        access(1, 1, 0, 2'd1, 0, 32'h0000_0006, $urandom, 32'h8765_4321, 0, 0);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] ra;
            ra = $urandom;
            access($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
                   1'($urandom), ra, $urandom, $urandom, $urandom_range(0, 3),
                   1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
